// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla instruction sequencer.
//   - opcode constants and instruction field positions
//   - sequencer FSM state type
//   - scoreboard entry type
//   - writes_reg(): whether an opcode writes the register file
package jericalla_pkg;

  localparam int unsigned REG_W  = 5;

  localparam int unsigned OPC_HI = 16;
  localparam int unsigned OPC_LO = 15;
  localparam int unsigned WA_HI  = 14;
  localparam int unsigned WA_LO  = 10;
  localparam int unsigned RA1_HI = 9;
  localparam int unsigned RA1_LO = 5;
  localparam int unsigned RA2_HI = 4;
  localparam int unsigned RA2_LO = 0;

  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_TERN  = 2'b10;
  localparam logic [1:0] OP_SW    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] addr;
  } sb_entry_t;

  // SW is the only opcode that does not write a register.
  function automatic logic writes_reg(input logic [1:0] opcode);
    return (opcode != OP_SW);
  endfunction

endpackage

// File: rtl/jericalla_marcador.sv
// RAW hazard scoreboard: a PIPE_DEPTH-deep shift register of pending
// register writes plus source-register comparators.
//   clk, rst    clock, asynchronous active-high reset
//   push        an instruction is issued this cycle
//   push_valid  the issued instruction writes push_addr
//   push_addr   destination register of the issued instruction
//   ra1, ra2    source registers of the instruction under check
//   hazard      a pending write matches ra1 or ra2
//   empty       no write will still be pending after this clock edge
module jericalla_marcador
  import jericalla_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_valid,
  input  logic [REG_W-1:0] push_addr,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic             hazard,
  output logic             empty
);

  sb_entry_t sb [PIPE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        sb[i] <= '0;
      end
    end else begin
      sb[0] <= {push & push_valid, push_addr};
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  // empty looks one edge ahead: the oldest entry shifts out on this edge,
  // so only younger entries (and a push) can keep a write pending. This
  // lets done rise in the first cycle the scoreboard is fully clear.
  always_comb begin
    hazard = 1'b0;
    empty  = ~(push & push_valid);
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (sb[i].valid && ((sb[i].addr == ra1) || (sb[i].addr == ra2))) begin
        hazard = 1'b1;
      end
    end
    for (int unsigned i = 0; i + 1 < PIPE_DEPTH; i++) begin
      if (sb[i].valid) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/jericalla_secuenciador.sv
// Jericalla instruction sequencer: fetches instructions from a synchronous
// ROM, holds each one in CHECK while a source register has a pending write,
// and issues them one at a time to the datapath.
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a run at address 0 (accepted in IDLE/DONE only)
//   prog_len     instructions in the run, latched when start is accepted
//   imem_addr    instruction-ROM address
//   imem_rd      ROM read enable, data returns the following cycle
//   imem_data    ROM read data
//   instruccion  instruction to the datapath (holds when instr_valid=0)
//   instr_valid  one-cycle pulse per issued instruction
//   busy         run in progress, falls with done
//   done         one-cycle pulse at run completion
//   stall_count  hazard stall cycles in the current run
// Build option: JERICALLA_STALL_CNT_EN enables the saturating stall
// counter; without it stall_count is constant zero.
module jericalla_secuenciador
  import jericalla_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INSTR_W    = 17,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  prog_len,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruccion,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   stall_count
);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  len;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] ir;
  logic               chk_first;
  logic [REG_W-1:0]   ra1;
  logic [REG_W-1:0]   ra2;
  logic               push;
  logic               push_valid;
  logic               hazard;
  logic               empty;

  assign pc_next = pc + ADDR_W'(1);

  // On the first CHECK cycle the instruction is still on the ROM bus.
  assign ra1 = chk_first ? imem_data[RA1_HI:RA1_LO] : ir[RA1_HI:RA1_LO];
  assign ra2 = chk_first ? imem_data[RA2_HI:RA2_LO] : ir[RA2_HI:RA2_LO];

  assign push       = (state == ST_ISSUE);
  assign push_valid = writes_reg(ir[OPC_HI:OPC_LO]);

  jericalla_marcador #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_marcador (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_valid (push_valid),
    .push_addr  (ir[WA_HI:WA_LO]),
    .ra1        (ra1),
    .ra2        (ra2),
    .hazard     (hazard),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      len         <= '0;
      ir          <= '0;
      chk_first   <= 1'b0;
      imem_addr   <= '0;
      imem_rd     <= 1'b0;
      instruccion <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      done        <= 1'b0;
      imem_rd     <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (prog_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              len       <= prog_len;
              pc        <= '0;
              busy      <= 1'b1;
              imem_rd   <= 1'b1;
              imem_addr <= '0;
              state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          chk_first <= 1'b1;
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          if (chk_first) begin
            ir        <= imem_data;
            chk_first <= 1'b0;
          end
          if (!hazard) begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          instruccion <= ir;
          instr_valid <= 1'b1;
          pc          <= pc_next;
          if (pc_next == len) begin
            state <= ST_DRAIN;
          end else begin
            imem_rd   <= 1'b1;
            imem_addr <= pc_next;
            state     <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JERICALLA_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
      stall_count <= '0;
    end else if ((state == ST_CHECK) && hazard && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule
